// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the serial pattern-scan controller.
// The reset pattern is 1010 with a length of 4.
package pattern_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DONE
   } state_e;

   localparam logic [3:0] DEF_PAT = 4'b1010;
   localparam logic [3:0] DEF_LEN = 4'd4;

endpackage

// File: rtl/pattern_scan_ctrl_match.sv
// Serial history shift register, fill counter and length-masked compare.
// hit is combinational and reflects the bit being consumed this cycle.
module pattern_match #(
   parameter int PLEN = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic            din,
   input  logic [PLEN-1:0] pat,
   input  logic [3:0]      len,
   output logic            hit
);

   localparam int FW = $clog2(PLEN + 1);

   logic [PLEN-1:0] hist_q;
   logic [PLEN-1:0] hist_d;
   logic [PLEN-1:0] mask;
   logic [FW-1:0]   fill_q;
   logic [FW-1:0]   fill_d;

   // Next history/fill and compare of the newest len bits.
   always_comb begin
      hist_d = {hist_q[PLEN-2:0], din};
      fill_d = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);
      mask   = '0;
      for (int i = 0; i < PLEN; i++) begin
         mask[i] = (i < int'(len));
      end
      hit = en
         && (int'(fill_d) >= int'(len))
         && ((hist_d & mask) == (pat & mask));
   end

   // Shift in consumed bits; clear on reset or a new arm.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (en) begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Programmable pattern-scan controller: config regs, FSM, match counter.
// All outputs are registered; the matcher lives in pattern_match.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int PLEN = 8,
   parameter int CW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [PLEN-1:0] cfg_pat,
   input  logic [3:0]      cfg_len,
   input  logic [CW-1:0]   cfg_limit,
   input  logic            start,
   input  logic            abort,
   input  logic            din,
   input  logic            din_valid,
   output logic            busy,
   output logic            match,
   output logic [CW-1:0]   count,
   output logic            done,
   output logic            cfg_err
);

   localparam logic [3:0] PLEN_L = 4'(PLEN);

   state_e          state_q;
   logic [PLEN-1:0] pat_q;
   logic [3:0]      len_q;
   logic [CW-1:0]   limit_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic            busy_q;
   logic            match_q;
   logic            done_q;
   logic            cfg_err_q;

   logic            m_en;
   logic            m_clr;
   logic            hit;
   logic            cfg_ok;
   logic            lim_hit;

   // Matcher control, saturating increment and limit detect.
   always_comb begin
      m_en    = (state_q == ST_ARMED) && din_valid && !abort;
      m_clr   = (state_q == ST_IDLE) && start;
      cfg_ok  = (cfg_len != 4'd0) && (cfg_len <= PLEN_L);
      count_d = (count_q == '1) ? count_q : count_q + CW'(1);
      lim_hit = (limit_q != '0) && (count_d == limit_q);
   end

   pattern_match #(
      .PLEN (PLEN)
   ) u_match (
      .clk (clk),
      .rst (rst),
      .clr (m_clr),
      .en  (m_en),
      .din (din),
      .pat (pat_q),
      .len (len_q),
      .hit (hit)
   );

   // FSM with config latch, counter and registered output pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pat_q     <= PLEN'(DEF_PAT);
         len_q     <= DEF_LEN;
         limit_q   <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         match_q   <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         match_q   <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_we) begin
                  if (cfg_ok) begin
                     pat_q   <= cfg_pat;
                     len_q   <= cfg_len;
                     limit_q <= cfg_limit;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
               if (start) begin
                  count_q <= '0;
                  state_q <= ST_ARMED;
                  busy_q  <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (hit) begin
                  count_q <= count_d;
                  match_q <= 1'b1;
                  if (lim_hit) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign match   = match_q;
   assign count   = count_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_q;

endmodule
